// File: rtl/key_pkg.sv
// Shared definitions for the key path: one-hot FSM encodings, 50 MHz timing
// defaults and the event payload carried by the key decoders.
package key_pkg;

    localparam int unsigned KEY_ST_W = 5;

    localparam logic [KEY_ST_W-1:0] ST_IDLE   = 5'b00001;
    localparam logic [KEY_ST_W-1:0] ST_PRESS1 = 5'b00010;
    localparam logic [KEY_ST_W-1:0] ST_WAIT2  = 5'b00100;
    localparam logic [KEY_ST_W-1:0] ST_PRESS2 = 5'b01000;
    localparam logic [KEY_ST_W-1:0] ST_LONG   = 5'b10000;

    // Timing defaults in 50 MHz clock cycles.
    localparam int unsigned LONG_1S      = 50_000_000;
    localparam int unsigned DCLICK_250MS = 12_500_000;
    localparam int unsigned REPEAT_200MS = 10_000_000;
    localparam int unsigned KEY_CNT_W    = 26;

    typedef struct packed {
        logic single_click;
        logic double_click;
        logic long_press;
        logic key_repeat;
    } key_evt_t;

    localparam key_evt_t KEY_EVT_NONE = '{default: 1'b0};

endpackage : key_pkg

// File: rtl/key_event_decoder_if.sv
// Key level in, gesture event pulses and busy out.
interface key_event_decoder_if;

    logic key_level;
    logic single_click;
    logic double_click;
    logic long_press;
    logic key_repeat;
    logic busy;

    // Decoder side.
    modport slave (
        input  key_level,
        output single_click,
        output double_click,
        output long_press,
        output key_repeat,
        output busy
    );

    // Key source / event consumer side.
    modport master (
        output key_level,
        input  single_click,
        input  double_click,
        input  long_press,
        input  key_repeat,
        input  busy
    );

endinterface : key_event_decoder_if

// File: rtl/key_edge_det.sv
// One-cycle rise/fall strobes of a synchronous key level; key_dly resets low so a
// key held through reset shows up as a rise on the first cycle after release.
module key_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic key_level,
    output logic rise,
    output logic fall
);

    logic key_dly_q;
    logic key_dly_d;

    always_comb begin
        key_dly_d = key_level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_dly_q <= 1'b0;
        end else begin
            key_dly_q <= key_dly_d;
        end
    end

    assign rise = key_level & ~key_dly_q;
    assign fall = ~key_level & key_dly_q;

endmodule : key_edge_det

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into single/double click, long press and
// auto-repeat one-cycle pulses.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT   = LONG_1S,
    parameter int unsigned DCLICK_CNT = DCLICK_250MS,
    parameter int unsigned REPEAT_CNT = REPEAT_200MS,
    parameter int unsigned CNT_W      = KEY_CNT_W
) (
    input logic               clk,
    input logic               rst,
    key_event_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);

    logic                rise;
    logic                fall;
    logic [KEY_ST_W-1:0] state_q;
    logic [KEY_ST_W-1:0] state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    key_evt_t            evt_q;
    key_evt_t            evt_d;

    key_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .key_level (bus.key_level),
        .rise      (rise),
        .fall      (fall)
    );

    // Next state, counter and event decode; key edges take priority over terminals.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        evt_d   = KEY_EVT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_TERM) begin
                    state_d          = ST_LONG;
                    cnt_d            = '0;
                    evt_d.long_press = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == DCLICK_TERM) begin
                    state_d            = ST_IDLE;
                    cnt_d              = '0;
                    evt_d.single_click = 1'b1;
                end
            end
            ST_PRESS2: begin
                cnt_d = '0;
                if (fall) begin
                    state_d            = ST_IDLE;
                    evt_d.double_click = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_TERM) begin
                    cnt_d            = '0;
                    evt_d.key_repeat = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            evt_q   <= KEY_EVT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign bus.single_click = evt_q.single_click;
    assign bus.double_click = evt_q.double_click;
    assign bus.long_press   = evt_q.long_press;
    assign bus.key_repeat   = evt_q.key_repeat;
    assign bus.busy         = (state_q != ST_IDLE);

endmodule : key_event_decoder

// File: tb/tb_key_event_decoder.sv
// Directed gesture scenarios for key_event_decoder with short timing constants.
module tb_key_event_decoder;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    key_event_decoder_if bus_if ();

    key_event_decoder #(
        .LONG_CNT   (20),
        .DCLICK_CNT (10),
        .REPEAT_CNT (5),
        .CNT_W      (26)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] evt_now();
        return {4'b0, bus_if.single_click, bus_if.double_click,
                bus_if.long_press, bus_if.key_repeat};
    endfunction

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Key high in [k0,k1] and [k2,k3]; optional reset pulse in cycle rc.
    // Expected pulses: single sc, double dc, long lp, repeats r0..r2; busy in [b0,b1] and [b2,b3].
    task automatic run_scn(input string nm,
                           input int k0, input int k1, input int k2, input int k3,
                           input int rc,
                           input int sc, input int dc, input int lp,
                           input int r0, input int r1, input int r2,
                           input int b0, input int b1, input int b2, input int b3);
        logic [7:0] exp_e;
        bus_if.key_level = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq({nm, " reset evt"}, evt_now(), 8'h00);
        check_eq({nm, " reset busy"}, {7'b0, bus_if.busy}, 8'h00);
        rst = 1'b0;
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk);
            #1;
            bus_if.key_level = in_rng(c, k0, k1) | in_rng(c, k2, k3);
            if (c == rc) begin
                rst = 1'b1;
                #1;
                check_eq($sformatf("%s async rst evt c%0d", nm, c), evt_now(), 8'h00);
                check_eq($sformatf("%s async rst busy c%0d", nm, c), {7'b0, bus_if.busy}, 8'h00);
            end
            @(negedge clk);
            exp_e = {4'b0, 1'(c == sc), 1'(c == dc), 1'(c == lp),
                     1'((c == r0) || (c == r1) || (c == r2))};
            check_eq($sformatf("%s evt c%0d", nm, c), evt_now(), exp_e);
            check_eq($sformatf("%s busy c%0d", nm, c), {7'b0, bus_if.busy},
                     {7'b0, in_rng(c, b0, b1) | in_rng(c, b2, b3)});
            if (c == rc) rst = 1'b0;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.key_level = 1'b0;
        //       name       key ranges        rst  sc  dc  lp  repeats      busy ranges
        run_scn("single",   10, 14, -1, -1,  -1,  26, -1, -1, -1, -1, -1,  11, 25, -1, -1);
        run_scn("double",   10, 12, 17, 19,  -1,  -1, 21, -1, -1, -1, -1,  11, 20, -1, -1);
        run_scn("long",     10, 49, -1, -1,  -1,  -1, -1, 31, 36, 41, 46,  11, 50, -1, -1);
        run_scn("lrace",    10, 29, -1, -1,  -1,  41, -1, -1, -1, -1, -1,  11, 40, -1, -1);
        run_scn("dcedge",   10, 12, 23, 25,  -1,  -1, 27, -1, -1, -1, -1,  11, 26, -1, -1);
        run_scn("midrst",   10, 14, 30, 34,  20,  46, -1, -1, -1, -1, -1,  11, 19, 31, 45);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_key_event_decoder
